regfile_2r1w_sb: RTL
====================

# regfile_2r1w_sb

Parametrised register file with two independent combinational read ports, one synchronous write port, optional write-to-read bypass, and a per-register busy scoreboard. It is the datapath register bank for the next-generation CPU datapath: instruction issue reserves a destination register, writeback clears the reservation, and operand fetch uses the busy flags to decide whether to stall. All storage clears on an asynchronous reset.

## Interface
- DATA_W, 16: register width in bits.
- ADDR_W, 3: register-number width; the bank holds NREGS = 2**ADDR_W registers.
- BYPASS, 1: when 1, a same-cycle write is forwarded to the read ports. When 0, reads return stored values only.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- write  in  1  write enable
- writenum  in  ADDR_W  destination register of write
- data_in  in  DATA_W  write data
- readnum_a  in  ADDR_W  port A register select
- readnum_b  in  ADDR_W  port B register select
- data_out_a  out  DATA_W  port A read data (combinational)
- data_out_b  out  DATA_W  port B read data (combinational)
- reserve  in  1  mark register reservenum busy
- reservenum  in  ADDR_W  register to reserve
- busy_a  out  1  scoreboard state of readnum_a
- busy_b  out  1  scoreboard state of readnum_b
- busy_vec  out  NREGS  raw scoreboard, bit i = register i busy

## Operation
- Storage: NREGS x DATA_W registers R[i] and NREGS busy bits B[i].
- Write: on posedge clk with write=1, R[writenum] <= data_in. There are no other register updates.
- Scoreboard, per register i, evaluated at posedge clk:
  - reserve && reservenum==i: B[i] <= 1. Reserve wins over a same-cycle write to i, because the new producer supersedes the old one.
  - else write && writenum==i: B[i] <= 0.
  - else B[i] holds its value.
  - Reserving a register that is already busy leaves it busy. This is not an error.
  - A write to a register that is not busy stores the data and leaves B at 0.
- Read, port X in {a,b}, purely combinational:
  - BYPASS=1 and write && writenum==readnum_x: data_out_x = data_in, and busy_x = B[readnum_x] & ~write_hit, where write_hit is this match. Busy_x is 0 in this case.
  - Otherwise: data_out_x = R[readnum_x] and busy_x = B[readnum_x].
  - BYPASS=0: busy_x = B[readnum_x] and data_out_x = R[readnum_x] always.
  - Both ports may select the same register. Each port then returns identical values.
  - A same-cycle reserve does not affect busy_x until after the edge.
- busy_vec = B, unaffected by bypass.

## Timing
- Reset is asynchronous. While reset=1, all R[i]=0 and B[i]=0 immediately, so data_out_a, data_out_b, busy_a, busy_b and busy_vec are all 0.
- Write, reserve and read inputs are ignored while reset=1.
- Deassertion of reset is synchronous to clk (caller's responsibility). The first capturing edge is the first rising edge with reset=0.
- Write latency: the data is visible on the non-bypassed read path in the same cycle after the edge, with latency 1 clk.
- With BYPASS=1, a read of the register being written has latency 0.
- Reserve-to-busy latency: 1 clk. Write-to-busy-clear latency: 1 clk on busy_vec, and 0 on busy_x when BYPASS=1.
- Reset asserted mid-cycle with write=1: the write is lost and the register reads 0.
- There are no combinational paths from reserve or reservenum to any output.

## Test plan
- Reset, then read all 8 registers on both ports → every read returns 0x0000 and busy_vec=8'h00. Then assert reset asynchronously between edges after writing R3=0xBEEF → data_out reads 0 before the next edge.
- Write R2=0x1234 and R5=0xABCD on consecutive edges, readnum_a=2, readnum_b=5 → data_out_a=0x1234 and data_out_b=0xABCD. Then readnum_a=readnum_b=5 → both ports read 0xABCD.
- BYPASS=1: R4=0x0001 stored, then write=1, writenum=4, data_in=0x00FF, readnum_a=4 in the same cycle → data_out_a=0x00FF before the edge. Repeat with BYPASS=0 → 0x0001 before the edge and 0x00FF after it.
- Reserve R6 → busy_vec[6]=1 and busy_a=1 for readnum_a=6 after the edge. Write R6=0x7777 → with BYPASS=1, busy_a=0 and data_out_a=0x7777 during the write cycle; busy_vec[6]=0 after the edge.
- Reserve R1 and write R1=0x5555 in the same cycle → R1=0x5555 and busy_vec[1]=1 after the edge. Reserve R1 again while busy → it stays busy. A write to a non-busy R0 → busy_vec[0] stays 0.
- Parameter sweep DATA_W=32, ADDR_W=4: write 0xDEADBEEF to R15, reserve R15, write R0 → R15 reads 0xDEADBEEF, and busy_vec=16'h8000 after the R0 write.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: 2-read/1-write register bank with optional write bypass and per-register busy scoreboard
module regfile_2r1w_sb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned NREGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reservenum,
  output logic              busy_a,
  output logic              busy_b,
  output logic [NREGS-1:0]  busy_vec
);
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, set_v, clr_v;
  logic hit_a, hit_b;
  assign set_v = reserve ? NREGS'(1) << reservenum : '0;
  assign clr_v = write ? NREGS'(1) << writenum : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (write) regs[writenum] <= data_in;
      busy <= set_v | (busy & ~clr_v);
    end
  // bypass is gated by reset so outputs stay zero while reset is held
  assign hit_a = (BYPASS != 0) && !reset && write && (writenum == readnum_a);
  assign hit_b = (BYPASS != 0) && !reset && write && (writenum == readnum_b);
  assign data_out_a = hit_a ? data_in : regs[readnum_a];
  assign data_out_b = hit_b ? data_in : regs[readnum_b];
  assign busy_a = busy[readnum_a] & ~hit_a;
  assign busy_b = busy[readnum_b] & ~hit_b;
  assign busy_vec = busy;
endmodule
